status_reg_unit: RTL and testbench

Holds the architectural NZCV status register for the ARM pipeline and drives the 4-bit status value consumed by the ID-stage condition checker. Takes the flags produced by the EXE-stage ALU and commits them when the instruction sets flags (S bit). Supplies a same-cycle forwarded value or a hazard stall so conditional instructions in ID always see correct flags. Honours the cache-miss freeze and branch flush, and keeps a sticky-overflow bit and an update counter for debug.

---
 rtl/status_reg_unit.sv | 109 ++++++++++
 tb/tb_status_reg_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_reg_unit.sv
// status_reg_unit: architectural NZCV status register with ID-stage flag supply.
// Define STATUS_FWD_EN to forward EXE flags combinationally instead of raising flag_hazard.
module status_reg_unit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             exe_s,
   input  logic [3:0]       exe_flags,
   input  logic             id_valid,
   input  logic [3:0]       id_cond,
   input  logic             clr_sticky,
   output logic [3:0]       sr_q,
   output logic [3:0]       status_out,
   output logic             flag_hazard,
   output logic             sticky_v,
   output logic [CNT_W-1:0] update_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             live_s;
   logic             commit_s;
   logic             cnt_sat_s;
   logic [3:0]       status_s;
   logic             hazard_s;
   logic [3:0]       sr_r;
   logic             sticky_r;
   logic [CNT_W-1:0] cnt_r;

   // Qualify the EXE flag write: live ignores freeze, commit does not.
   always_comb begin
      live_s    = exe_s & ~flush;
      commit_s  = live_s & ~freeze;
      cnt_sat_s = (cnt_r == CNT_MAX);
   end

   // Committed NZCV register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_r <= 4'b0000;
      end else if (commit_s) begin
         sr_r <= exe_flags;
      end else begin
         sr_r <= sr_r;
      end
   end

   // Sticky overflow: a committed V=1 beats a simultaneous clear; freeze holds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_r <= 1'b0;
      end else if (freeze) begin
         sticky_r <= sticky_r;
      end else if (commit_s & exe_flags[0]) begin
         sticky_r <= 1'b1;
      end else if (clr_sticky) begin
         sticky_r <= 1'b0;
      end else begin
         sticky_r <= sticky_r;
      end
   end

   // Saturating count of committed flag writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (commit_s & ~cnt_sat_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

`ifdef STATUS_FWD_EN
   logic unused_id_s;
   assign unused_id_s = ^{id_valid, id_cond};

   // Forward in-flight flags so ID never has to wait.
   always_comb begin
      hazard_s = 1'b0;
      if (live_s) begin
         status_s = exe_flags;
      end else begin
         status_s = sr_r;
      end
   end
`else
   // Without forwarding, a conditional ID instruction must stall behind a live flag write.
   always_comb begin
      status_s = sr_r;
      if (id_valid & live_s & (id_cond < 4'd14)) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end
`endif

   assign sr_q        = sr_r;
   assign sticky_v    = sticky_r;
   assign update_cnt  = cnt_r;
   assign status_out  = status_s;
   assign flag_hazard = hazard_s;

endmodule

// File: tb/tb_status_reg_unit.sv
// tb_status_reg_unit: directed stimulus with a per-cycle behavioural model plus literal checks.
// Honours STATUS_FWD_EN the same way as the design.
module tb_status_reg_unit;

   localparam int CNT_W = 8;
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             freeze = 1'b0;
   logic             flush = 1'b0;
   logic             exe_s = 1'b0;
   logic [3:0]       exe_flags = 4'b0000;
   logic             id_valid = 1'b0;
   logic [3:0]       id_cond = 4'd0;
   logic             clr_sticky = 1'b0;
   logic [3:0]       sr_q;
   logic [3:0]       status_out;
   logic             flag_hazard;
   logic             sticky_v;
   logic [CNT_W-1:0] update_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [3:0] m_sr = 4'b0000;
   logic       m_sticky = 1'b0;
   int         m_cnt = 0;
   logic       model_ok = 1'b0;

   status_reg_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .exe_s(exe_s),
      .exe_flags(exe_flags), .id_valid(id_valid), .id_cond(id_cond),
      .clr_sticky(clr_sticky), .sr_q(sr_q), .status_out(status_out),
      .flag_hazard(flag_hazard), .sticky_v(sticky_v), .update_cnt(update_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: what the architectural state must become on each edge.
   always @(posedge clk) begin
      bit commit;
      commit = exe_s && !flush && !freeze;
      if (rst) begin
         m_sr     <= 4'b0000;
         m_sticky <= 1'b0;
         m_cnt    <= 0;
         model_ok <= 1'b1;
      end else begin
         if (commit) m_sr <= exe_flags;
         if (!freeze) begin
            if (commit && exe_flags[0]) m_sticky <= 1'b1;
            else if (clr_sticky) m_sticky <= 1'b0;
         end
         if (commit && m_cnt < CNT_TOP) m_cnt <= m_cnt + 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [3:0] exp_status;
      logic       exp_haz;
      bit         live;
      if (model_ok) begin
         live = exe_s && !flush;
`ifdef STATUS_FWD_EN
         exp_status = live ? exe_flags : m_sr;
         exp_haz    = 1'b0;
`else
         exp_status = m_sr;
         exp_haz    = id_valid && live && (id_cond < 4'd14);
`endif
         chk("m_sr_q", 32'(sr_q), 32'(m_sr));
         chk("m_sticky", 32'(sticky_v), 32'(m_sticky));
         chk("m_cnt", 32'(update_cnt), 32'(m_cnt));
         chk("m_status", 32'(status_out), 32'(exp_status));
         chk("m_hazard", 32'(flag_hazard), 32'(exp_haz));
      end
   end

   initial begin
      // reset state
      step(); step();
      chk("rst_sr", 32'(sr_q), 32'h0);
      chk("rst_sticky", 32'(sticky_v), 32'h0);
      chk("rst_cnt", 32'(update_cnt), 32'h0);
      chk("rst_status", 32'(status_out), 32'h0);
      chk("rst_hazard", 32'(flag_hazard), 32'h0);
      rst = 1'b0;

      // first commit
      exe_s = 1'b1; exe_flags = 4'b0100;
      step();
      exe_s = 1'b0;
      chk("c1_sr", 32'(sr_q), 32'h4);
      chk("c1_cnt", 32'(update_cnt), 32'd1);
      chk("c1_sticky", 32'(sticky_v), 32'h0);

      // freeze holds a pending commit for 3 cycles
      exe_s = 1'b1; exe_flags = 4'b1001; freeze = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("frz_sr", 32'(sr_q), 32'h4);
         chk("frz_cnt", 32'(update_cnt), 32'd1);
      end
      freeze = 1'b0;
      step();
      exe_s = 1'b0;
      chk("unfrz_sr", 32'(sr_q), 32'h9);
      chk("unfrz_cnt", 32'(update_cnt), 32'd2);
      chk("unfrz_sticky", 32'(sticky_v), 32'h1);

      // flushed write: no hazard, no forward, no commit
      exe_s = 1'b1; flush = 1'b1; exe_flags = 4'b1111; id_valid = 1'b1; id_cond = 4'd0;
      #1;
      chk("flush_haz", 32'(flag_hazard), 32'h0);
      chk("flush_status", 32'(status_out), 32'h9);
      step();
      chk("flush_sr", 32'(sr_q), 32'h9);
      chk("flush_cnt", 32'(update_cnt), 32'd2);

      // live write vs conditional ID instruction
      flush = 1'b0; exe_flags = 4'b0010; id_cond = 4'd0;
      #1;
`ifdef STATUS_FWD_EN
      chk("live_haz_c0", 32'(flag_hazard), 32'h0);
      chk("live_status", 32'(status_out), 32'h2);
`else
      chk("live_haz_c0", 32'(flag_hazard), 32'h1);
      chk("live_status", 32'(status_out), 32'h9);
`endif
      id_cond = 4'd14;
      #1;
      chk("live_haz_c14", 32'(flag_hazard), 32'h0);
      id_cond = 4'd15;
      #1;
      chk("live_haz_c15", 32'(flag_hazard), 32'h0);
      id_cond = 4'd13;
      #1;
`ifdef STATUS_FWD_EN
      chk("live_haz_c13", 32'(flag_hazard), 32'h0);
`else
      chk("live_haz_c13", 32'(flag_hazard), 32'h1);
`endif
      exe_s = 1'b0; id_valid = 1'b0;
      #1;
      chk("idle_haz", 32'(flag_hazard), 32'h0);

      // sticky overflow set/clear priority and freeze hold
      clr_sticky = 1'b1;
      step();
      chk("stk_clr", 32'(sticky_v), 32'h0);
      exe_s = 1'b1; exe_flags = 4'b0001;
      step();
      exe_s = 1'b0;
      chk("stk_set_wins", 32'(sticky_v), 32'h1);
      chk("stk_cnt", 32'(update_cnt), 32'd3);
      step();
      chk("stk_clr2", 32'(sticky_v), 32'h0);
      clr_sticky = 1'b0; exe_s = 1'b1;
      step();
      exe_s = 1'b0; freeze = 1'b1; clr_sticky = 1'b1;
      step();
      chk("stk_frz_hold", 32'(sticky_v), 32'h1);
      freeze = 1'b0;
      step();
      chk("stk_clr3", 32'(sticky_v), 32'h0);
      clr_sticky = 1'b0;

      // mixed directed sequence, checked by the model each cycle
      for (int i = 0; i < 48; i++) begin
         exe_s      = ((i & 1) != 0) || ((i & 4) != 0);
         flush      = (i % 5) == 0;
         freeze     = (i % 7) == 3;
         exe_flags  = 4'((i * 3) % 16);
         id_valid   = (i & 2) != 0;
         id_cond    = 4'((i * 5) % 16);
         clr_sticky = (i % 6) == 4;
         step();
      end
      flush = 1'b0; freeze = 1'b0; id_valid = 1'b0; clr_sticky = 1'b0; exe_s = 1'b0;

      // counter saturation, then reset mid-sequence
      rst = 1'b1;
      step();
      rst = 1'b0;
      exe_s = 1'b1;
      for (int i = 0; i < 260; i++) begin
         exe_flags = 4'(i % 16);
         step();
      end
      chk("sat_cnt", 32'(update_cnt), 32'd255);
      step();
      chk("sat_hold", 32'(update_cnt), 32'd255);
      exe_flags = 4'b1011;
      rst = 1'b1;
      step();
      chk("mid_rst_sr", 32'(sr_q), 32'h0);
      chk("mid_rst_sticky", 32'(sticky_v), 32'h0);
      chk("mid_rst_cnt", 32'(update_cnt), 32'h0);
      rst = 1'b0;
      step();
      chk("post_rst_sr", 32'(sr_q), 32'hb);
      chk("post_rst_cnt", 32'(update_cnt), 32'd1);
      exe_s = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
